conv_psum_acc4: RTL and testbench

CONV_PSUM_ACC4 -- requirements
Module: conv_psum_acc4

---
 rtl/conv_psum_acc4.sv | 162 ++++++++++++++++
 tb/tb_conv_psum_acc4.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_psum_acc4.sv
// conv_psum_acc4
//   Accumulates four lanes of signed channel-group partial sums for one 2x2
//   output window. Each window starts from a bias, takes num_grp beats and
//   reports the saturated lane sums plus a sticky saturation flag for one
//   cycle.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   i_start              begin a window (also aborts a running one)
//   i_bias [PSUM_W]      signed bias loaded into all four lanes
//   i_num_grp [CNT_W]    beats per window, 0 is treated as 1
//   i_vld                partial-sum beat valid
//   i_psum0..3 [PSUM_W]  signed lane partial sums (pixels 0..3)
//   o_vld                one-cycle pulse, window result valid
//   o_sum0..3 [ACC_W]    signed accumulated window sums
//   o_sat                at least one lane clamped in the reported window
//   o_busy               window in progress

// One lane: accumulator register plus saturating adder.
module conv_psum_lane #(
    parameter int PSUM_W = 16,
    parameter int ACC_W  = 22
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic              beat,
    input  logic [PSUM_W-1:0] bias,
    input  logic [PSUM_W-1:0] psum,
    output logic [ACC_W-1:0]  sum_nxt,
    output logic              clamp
);
    localparam logic [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W:0]   wide;

    always_comb begin
        wide    = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-PSUM_W){psum[PSUM_W-1]}}, psum};
        // the two top bits disagree only when the ACC_W-bit result overflowed
        clamp   = wide[ACC_W] ^ wide[ACC_W-1];
        sum_nxt = clamp ? (wide[ACC_W] ? MINV : MAXV) : wide[ACC_W-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            acc_q <= '0;
        else if (load)
            acc_q <= {{(ACC_W-PSUM_W){bias[PSUM_W-1]}}, bias};
        else if (beat)
            acc_q <= sum_nxt;
    end
endmodule

module conv_psum_acc4 #(
    parameter int PSUM_W = 16,
    parameter int ACC_W  = 22,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_start,
    input  logic signed [PSUM_W-1:0] i_bias,
    input  logic        [CNT_W-1:0]  i_num_grp,
    input  logic                     i_vld,
    input  logic signed [PSUM_W-1:0] i_psum0,
    input  logic signed [PSUM_W-1:0] i_psum1,
    input  logic signed [PSUM_W-1:0] i_psum2,
    input  logic signed [PSUM_W-1:0] i_psum3,
    output logic                     o_vld,
    output logic signed [ACC_W-1:0]  o_sum0,
    output logic signed [ACC_W-1:0]  o_sum1,
    output logic signed [ACC_W-1:0]  o_sum2,
    output logic signed [ACC_W-1:0]  o_sum3,
    output logic                     o_sat,
    output logic                     o_busy
);
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q, ngrp_q;
    logic             sat_q;
    logic             beat, last;

    logic [NUM_LANES-1:0][PSUM_W-1:0] psum_v;
    logic [NUM_LANES-1:0][ACC_W-1:0]  sum_nxt, sum_q;
    logic [NUM_LANES-1:0]             clamp;

    assign psum_v = {i_psum3, i_psum2, i_psum1, i_psum0};

    // i_start wins over i_vld in every state, so a beat only counts in ACC
    // without a concurrent start.
    assign beat = (state_q == ACC) && i_vld && !i_start;
    assign last = beat && (cnt_q == ngrp_q - CNT_W'(1));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            conv_psum_lane #(.PSUM_W(PSUM_W), .ACC_W(ACC_W)) u_lane (
                .clk     (clk),
                .rstn    (rstn),
                .load    (i_start),
                .beat    (beat),
                .bias    (i_bias),
                .psum    (psum_v[gi]),
                .sum_nxt (sum_nxt[gi]),
                .clamp   (clamp[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (i_start) state_d = ACC;
            ACC: begin
                if (i_start)   state_d = ACC;
                else if (last) state_d = OUT;
            end
            OUT:     state_d = i_start ? ACC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ngrp_q  <= '0;
            sat_q   <= 1'b0;
            sum_q   <= '0;
            o_sat   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (i_start) begin
                cnt_q  <= '0;
                ngrp_q <= (i_num_grp == '0) ? CNT_W'(1) : i_num_grp;
                sat_q  <= 1'b0;
            end else if (beat) begin
                cnt_q <= cnt_q + CNT_W'(1);
                sat_q <= sat_q | (|clamp);
            end
            // results are captured straight from the adders so the final
            // beat's value and clamp land in the same OUT cycle
            if (last) begin
                sum_q <= sum_nxt;
                o_sat <= sat_q | (|clamp);
            end
        end
    end

    assign o_vld  = (state_q == OUT);
    assign o_busy = (state_q == ACC);
    assign o_sum0 = sum_q[0];
    assign o_sum1 = sum_q[1];
    assign o_sum2 = sum_q[2];
    assign o_sum3 = sum_q[3];
endmodule

// File: tb/tb_conv_psum_acc4.sv
module tb_conv_psum_acc4;
    localparam int PSUM_W = 16;
    localparam int ACC_W  = 22;
    localparam int CNT_W  = 8;
    localparam longint AMAX = 2097151;
    localparam longint AMIN = -2097152;

    logic                     clk, rstn;
    logic                     i_start, i_vld;
    logic signed [PSUM_W-1:0] i_bias;
    logic        [CNT_W-1:0]  i_num_grp;
    logic signed [PSUM_W-1:0] i_psum0, i_psum1, i_psum2, i_psum3;
    logic                     o_vld, o_sat, o_busy;
    logic signed [ACC_W-1:0]  o_sum0, o_sum1, o_sum2, o_sum3;

    conv_psum_acc4 #(.PSUM_W(PSUM_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .i_start(i_start), .i_bias(i_bias),
        .i_num_grp(i_num_grp), .i_vld(i_vld),
        .i_psum0(i_psum0), .i_psum1(i_psum1), .i_psum2(i_psum2), .i_psum3(i_psum3),
        .o_vld(o_vld), .o_sum0(o_sum0), .o_sum1(o_sum1), .o_sum2(o_sum2),
        .o_sum3(o_sum3), .o_sat(o_sat), .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    longint prev_sum[4];
    bit     prev_sat;
    int     bp[128][4];

    task automatic chk(input string tag, input logic signed [63:0] obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint lane_out(input int l);
        case (l)
            0:       return longint'(o_sum0);
            1:       return longint'(o_sum1);
            2:       return longint'(o_sum2);
            default: return longint'(o_sum3);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_psum();
        i_psum0 = PSUM_W'($urandom);
        i_psum1 = PSUM_W'($urandom);
        i_psum2 = PSUM_W'($urandom);
        i_psum3 = PSUM_W'($urandom);
    endtask

    task automatic set_psum(input int b);
        i_psum0 = PSUM_W'(bp[b][0]);
        i_psum1 = PSUM_W'(bp[b][1]);
        i_psum2 = PSUM_W'(bp[b][2]);
        i_psum3 = PSUM_W'(bp[b][3]);
    endtask

    task automatic check_held(input string tag);
        for (int l = 0; l < 4; l++)
            chk($sformatf("%s_hold_sum%0d", tag, l), lane_out(l), prev_sum[l]);
        chk({tag, "_hold_sat"}, o_sat, longint'(prev_sat));
    endtask

    function automatic int rnd16();
        logic signed [15:0] v;
        v = 16'($urandom);
        return int'(v);
    endfunction

    task automatic fill_rand(input int nb, input bit extreme);
        for (int b = 0; b < nb; b++)
            for (int l = 0; l < 4; l++)
                bp[b][l] = extreme ? ((l % 2 == 1) ? -32768 : 32767) : rnd16();
    endtask

    task automatic start_win(input string tag, input int bias, input int ng, input bit vld_too);
        i_start   = 1'b1;
        i_bias    = PSUM_W'(bias);
        i_num_grp = CNT_W'(ng);
        i_vld     = vld_too;
        rand_psum();
        step();
        i_start = 1'b0;
        i_vld   = 1'b0;
        chk({tag, "_start_busy"}, o_busy, 1);
        chk({tag, "_start_vld"}, o_vld, 0);
        check_held(tag);
    endtask

    // gaps: 0 none, 1 exactly one idle cycle before every beat but the first, 2 random
    task automatic feed(input string tag, input int nb, input int gaps);
        for (int b = 0; b < nb; b++) begin
            if (b > 0 && gaps == 1) begin
                i_vld = 1'b0;
                rand_psum();
                step();
                chk({tag, "_gap_vld"}, o_vld, 0);
                chk({tag, "_gap_busy"}, o_busy, 1);
            end
            while (gaps == 2 && $urandom_range(0, 2) == 0) begin
                i_vld = 1'b0;
                rand_psum();
                i_num_grp = CNT_W'($urandom);
                step();
                chk({tag, "_gap_vld"}, o_vld, 0);
                chk({tag, "_gap_busy"}, o_busy, 1);
            end
            i_vld = 1'b1;
            set_psum(b);
            if (gaps == 2) i_num_grp = CNT_W'($urandom);
            step();
            i_vld = 1'b0;
            if (b < nb - 1) begin
                chk({tag, "_beat_vld"}, o_vld, 0);
                chk({tag, "_beat_busy"}, o_busy, 1);
            end
        end
    endtask

    // Reference: bias plus each beat, clamped after every addition.
    task automatic expect_result(input string tag, input int bias, input int nb);
        longint s[4];
        bit     sat;
        sat = 1'b0;
        for (int l = 0; l < 4; l++) s[l] = bias;
        for (int b = 0; b < nb; b++)
            for (int l = 0; l < 4; l++) begin
                s[l] = s[l] + bp[b][l];
                if (s[l] > AMAX) begin s[l] = AMAX; sat = 1'b1; end
                if (s[l] < AMIN) begin s[l] = AMIN; sat = 1'b1; end
            end
        chk({tag, "_out_vld"}, o_vld, 1);
        chk({tag, "_out_busy"}, o_busy, 0);
        for (int l = 0; l < 4; l++)
            chk($sformatf("%s_sum%0d", tag, l), lane_out(l), s[l]);
        chk({tag, "_sat"}, o_sat, longint'(sat));
        for (int l = 0; l < 4; l++) prev_sum[l] = s[l];
        prev_sat = sat;
    endtask

    task automatic window(input string tag, input int bias, input int ng, input int gaps, input bit vld_on_start);
        int nb;
        nb = (ng == 0) ? 1 : ng;
        start_win(tag, bias, ng, vld_on_start);
        feed(tag, nb, gaps);
        expect_result(tag, bias, nb);
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            i_start = 1'b0;
            i_vld   = 1'($urandom);
            rand_psum();
            step();
            chk({tag, "_idle_vld"}, o_vld, 0);
            chk({tag, "_idle_busy"}, o_busy, 0);
            check_held(tag);
        end
        i_vld = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; i_start = 1'b0; i_vld = 1'b0; i_bias = '0; i_num_grp = '0;
        i_psum0 = '0; i_psum1 = '0; i_psum2 = '0; i_psum3 = '0;
        for (int l = 0; l < 4; l++) prev_sum[l] = 0;
        prev_sat = 1'b0;

        // reset state
        #12;
        chk("rst_vld", o_vld, 0);
        chk("rst_busy", o_busy, 0);
        check_held("rst");
        rstn = 1'b1;
        step();
        idle("post_rst", 1);

        // basic window
        for (int b = 0; b < 3; b++) begin
            bp[b][0] = 1; bp[b][1] = 2; bp[b][2] = 3; bp[b][3] = 4;
        end
        window("basic", 10, 3, 0, 1'b0);
        chk("basic_c0", o_sum0, 13);
        chk("basic_c1", o_sum1, 16);
        chk("basic_c2", o_sum2, 19);
        chk("basic_c3", o_sum3, 22);
        idle("basic", 2);

        // saturation
        fill_rand(100, 1'b0);
        for (int b = 0; b < 100; b++) begin bp[b][0] = 32767; bp[b][1] = -32768; end
        window("sat", 32767, 100, 0, 1'b0);
        chk("sat_c0", o_sum0, 2097151);
        chk("sat_c1", o_sum1, -2097152);
        chk("sat_flag", o_sat, 1);
        idle("sat", 1);

        // gapped, then back-to-back start during OUT
        fill_rand(2, 1'b0);
        window("gap", rnd16(), 2, 1, 1'b0);
        fill_rand(3, 1'b0);
        window("b2b", rnd16(), 3, 0, 1'b1);
        idle("b2b", 1);

        // abort after 2 of 4 beats with a valid beat on the restart cycle
        start_win("abort_a", 1000, 4, 1'b0);
        fill_rand(2, 1'b0);
        feed("abort_a", 2, 0);
        chk("abort_mid_vld", o_vld, 0);
        chk("abort_mid_busy", o_busy, 1);
        fill_rand(4, 1'b0);
        window("abort_b", 7, 4, 0, 1'b1);
        idle("abort", 1);

        // num_grp = 0 behaves as one beat
        bp[0][0] = 5; bp[0][1] = 0; bp[0][2] = -1; bp[0][3] = 7;
        window("ng0", -5, 0, 0, 1'b0);
        chk("ng0_c0", o_sum0, 0);
        chk("ng0_c1", o_sum1, -5);
        chk("ng0_c2", o_sum2, -6);
        chk("ng0_c3", o_sum3, 2);
        idle("ng0", 1);

        // asynchronous reset mid-window
        start_win("rstmid", 50, 5, 1'b0);
        fill_rand(2, 1'b0);
        feed("rstmid", 2, 0);
        #3;
        rstn = 1'b0;
        #1;
        for (int l = 0; l < 4; l++) prev_sum[l] = 0;
        prev_sat = 1'b0;
        chk("rstmid_vld", o_vld, 0);
        chk("rstmid_busy", o_busy, 0);
        check_held("rstmid");
        step();
        #2;
        rstn = 1'b1;
        fill_rand(3, 1'b0);
        window("after_rst", rnd16(), 3, 2, 1'b0);
        idle("after_rst", 2);

        // randomized windows
        for (int k = 0; k < 25; k++) begin
            int  ng, bias;
            bit  ext;
            ext  = ($urandom_range(0, 4) == 0);
            ng   = ext ? int'($urandom_range(60, 80)) : int'($urandom_range(0, 6));
            bias = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 32767 : -32768) : rnd16();
            fill_rand((ng == 0) ? 1 : ng, ext);
            window($sformatf("rnd%0d", k), bias, ng, 2, 1'($urandom));
            if ($urandom_range(0, 1) == 1) idle($sformatf("rnd%0d", k), int'($urandom_range(1, 2)));
        end
        idle("end", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
